// File: rtl/hack_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : hack_data_memory
// Description : Data-memory responder for the HACK CPU data port. Decodes the
//               HACK memory map into general RAM (0x0000), screen buffer
//               (0x4000) and a read-only keyboard register (0x6000). Reads are
//               combinational, writes take effect on the rising edge.
//               It also contains a free-running screen scanner for the display
//               side, and a valid/ready keyboard latch.
//               Optional feature macro: HACK_MEM_OOR_TRAP_EN adds the sticky
//               out-of-range access flag output oor_flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_data_memory #(
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] kbd_code,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    input  logic        kbd_release,
    input  logic        scan_en,
    output logic [12:0] scan_addr,
    output logic [15:0] scan_data,
    output logic        frame_start
`ifdef HACK_MEM_OOR_TRAP_EN
    ,
    output logic        oor_flag
`endif
);

    // ------------------------------------------------------------------------
    // Memory-map constants
    // ------------------------------------------------------------------------
    localparam int          c_RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          c_SCR_AW    = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;
    localparam logic [14:0] c_SCR_BASE  = 15'h4000;
    localparam logic [14:0] c_KBD_ADDR  = 15'h6000;
    // End addresses kept one bit wider so a full-size region cannot overflow
    localparam logic [15:0] c_RAM_END   = 16'(RAM_WORDS);
    localparam logic [15:0] c_SCR_END   = 16'(32'h4000 + SCREEN_WORDS);
    localparam logic [12:0] c_SCAN_LAST = 13'(SCREEN_WORDS - 1);

    // ------------------------------------------------------------------------
    // Keyboard handshake states
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        KBD_IDLE = 1'b0,
        KBD_HELD = 1'b1
    } kbd_state_t;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [15:0]          r_ram    [RAM_WORDS];
    logic [15:0]          r_screen [SCREEN_WORDS];

    kbd_state_t           r_kbd_state;
    kbd_state_t           w_kbd_state_nxt;
    logic [15:0]          r_kbd;
    logic [15:0]          w_kbd_nxt;
    logic                 w_kbd_ready;

    logic [12:0]          r_scan_addr;
    logic [15:0]          r_scan_data;
    logic                 r_frame_start;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic                 w_ram_sel;
    logic                 w_scr_sel;
    logic                 w_kbd_sel;
    logic [c_RAM_AW-1:0]  w_ram_idx;
    logic [c_SCR_AW-1:0]  w_scr_idx;
    logic [c_SCR_AW-1:0]  w_scan_idx;

    // RAM region may be smaller than its 16K window; the gap is unpopulated.
    assign w_ram_sel  = ({1'b0, addressM} < c_RAM_END) && (addressM < c_SCR_BASE);
    // Screen region likewise may be smaller than its 8K window.
    assign w_scr_sel  = (addressM >= c_SCR_BASE) &&
                        ({1'b0, addressM} < c_SCR_END) &&
                        (addressM < c_KBD_ADDR);
    assign w_kbd_sel  = (addressM == c_KBD_ADDR);

    // Both regions are aligned to their window, so low address bits index them.
    assign w_ram_idx  = addressM[c_RAM_AW-1:0];
    assign w_scr_idx  = addressM[c_SCR_AW-1:0];
    assign w_scan_idx = r_scan_addr[c_SCR_AW-1:0];

    // Combinational CPU read mux; unmapped addresses read as zero.
    always_comb begin
        inM = 16'h0000;
        if (w_ram_sel) begin
            inM = r_ram[w_ram_idx];
        end else if (w_scr_sel) begin
            inM = r_screen[w_scr_idx];
        end else if (w_kbd_sel) begin
            inM = r_kbd;
        end
    end

    // CPU writes into RAM or screen; keyboard and unmapped writes are dropped.
    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (writeM && w_ram_sel) begin
            r_ram[w_ram_idx] <= outM;
        end
        if (writeM && w_scr_sel) begin
            r_screen[w_scr_idx] <= outM;
        end
    end

    // ------------------------------------------------------------------------
    // Keyboard latch
    // ------------------------------------------------------------------------
    // State and code register for the keyboard handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kbd_state <= KBD_IDLE;
            r_kbd       <= 16'h0000;
        end else begin
            r_kbd_state <= w_kbd_state_nxt;
            r_kbd       <= w_kbd_nxt;
        end
    end

    // Next-state logic: a new code is only taken while idle (valid beats
    // release in that state); a held code is cleared on release.
    always_comb begin
        w_kbd_state_nxt = r_kbd_state;
        w_kbd_nxt       = r_kbd;
        w_kbd_ready     = 1'b0;
        case (r_kbd_state)
            KBD_IDLE: begin
                w_kbd_ready = 1'b1;
                if (kbd_valid) begin
                    w_kbd_nxt       = kbd_code;
                    w_kbd_state_nxt = KBD_HELD;
                end
            end
            KBD_HELD: begin
                if (kbd_release) begin
                    w_kbd_nxt       = 16'h0000;
                    w_kbd_state_nxt = KBD_IDLE;
                end
            end
            default: begin
                w_kbd_nxt       = 16'h0000;
                w_kbd_state_nxt = KBD_IDLE;
            end
        endcase
    end

    assign kbd_ready = w_kbd_ready;

    // ------------------------------------------------------------------------
    // Screen scanner
    // ------------------------------------------------------------------------
    // Address counter, registered read-out and wrap pulse. The screen read uses
    // the pre-edge array contents, so a same-cycle CPU write to the scanned
    // word is seen only on the next pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_addr   <= 13'd0;
            r_scan_data   <= 16'h0000;
            r_frame_start <= 1'b0;
        end else begin
            r_scan_data   <= r_screen[w_scan_idx];
            r_frame_start <= 1'b0;
            if (scan_en) begin
                if (r_scan_addr == c_SCAN_LAST) begin
                    r_scan_addr   <= 13'd0;
                    r_frame_start <= 1'b1;
                end else begin
                    r_scan_addr   <= r_scan_addr + 13'd1;
                end
            end
        end
    end

    assign scan_addr   = r_scan_addr;
    assign scan_data   = r_scan_data;
    assign frame_start = r_frame_start;

`ifdef HACK_MEM_OOR_TRAP_EN
    // ------------------------------------------------------------------------
    // Out-of-range trap
    // ------------------------------------------------------------------------
    logic w_oor;
    logic r_oor;

    // Reads are continuous, so any cycle presenting an unmapped address counts.
    assign w_oor = !(w_ram_sel || w_scr_sel || w_kbd_sel);

    // Sticky flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oor <= 1'b0;
        end else if (w_oor) begin
            r_oor <= 1'b1;
        end
    end

    assign oor_flag = r_oor;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hack_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_data_memory
// Description : Self-checking bench for hack_data_memory. Expected values are
//               queued as stimulus is applied and compared against the DUT
//               outputs once they are due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_data_memory;

    localparam int c_SEL_INM   = 0;
    localparam int c_SEL_READY = 1;
    localparam int c_SEL_SADDR = 2;
    localparam int c_SEL_SDATA = 3;
    localparam int c_SEL_FRAME = 4;
    localparam int c_SEL_OOR   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] kbd_code;
    logic        kbd_valid;
    logic        kbd_ready;
    logic        kbd_release;
    logic        scan_en;
    logic [12:0] scan_addr;
    logic [15:0] scan_data;
    logic        frame_start;
`ifdef HACK_MEM_OOR_TRAP_EN
    logic        oor_flag;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       errors = 0;
    int       checks = 0;
    int       frame_pulses;

    hack_data_memory u_dut (
        .clk         (clk),
        .rst         (rst),
        .addressM    (addressM),
        .outM        (outM),
        .writeM      (writeM),
        .inM         (inM),
        .kbd_code    (kbd_code),
        .kbd_valid   (kbd_valid),
        .kbd_ready   (kbd_ready),
        .kbd_release (kbd_release),
        .scan_en     (scan_en),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .frame_start (frame_start)
`ifdef HACK_MEM_OOR_TRAP_EN
        ,
        .oor_flag    (oor_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] observed(input int sel);
        case (sel)
            c_SEL_INM:   return inM;
            c_SEL_READY: return {15'd0, kbd_ready};
            c_SEL_SADDR: return {3'd0, scan_addr};
            c_SEL_SDATA: return scan_data;
            c_SEL_FRAME: return {15'd0, frame_start};
`ifdef HACK_MEM_OOR_TRAP_EN
            c_SEL_OOR:   return {15'd0, oor_flag};
`endif
            default:     return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [15:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    // Compare every queued expectation against the present outputs.
    task automatic drain();
        sb_item_t it;
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, observed(it.sel), it.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        addressM = a;
        outM     = d;
        writeM   = 1'b1;
        tick();
        writeM   = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        addressM    = 15'h6000;
        outM        = 16'h0000;
        writeM      = 1'b0;
        kbd_code    = 16'h0000;
        kbd_valid   = 1'b0;
        kbd_release = 1'b0;
        scan_en     = 1'b0;

        // Reset state
        #2;
        expect_val("rst_kbd", c_SEL_INM, 16'h0000);
        expect_val("rst_ready", c_SEL_READY, 16'h0001);
        expect_val("rst_scan_addr", c_SEL_SADDR, 16'h0000);
        expect_val("rst_scan_data", c_SEL_SDATA, 16'h0000);
        expect_val("rst_frame", c_SEL_FRAME, 16'h0000);
`ifdef HACK_MEM_OOR_TRAP_EN
        expect_val("rst_oor", c_SEL_OOR, 16'h0000);
`endif
        drain();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // RAM write/read and unmapped read
        cpu_write(15'h0010, 16'h1234);
        addressM = 15'h0010;
        expect_val("ram_rd", c_SEL_INM, 16'h1234);
        drain();
        cpu_write(15'h3FFF, 16'hC0DE);
        addressM = 15'h3FFF;
        expect_val("ram_top_rd", c_SEL_INM, 16'hC0DE);
        drain();
        addressM = 15'h6001;
        expect_val("oor_rd_6001", c_SEL_INM, 16'h0000);
        drain();

        // Keyboard handshake
        addressM  = 15'h6000;
        kbd_code  = 16'h0041;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        expect_val("kbd_accept", c_SEL_INM, 16'h0041);
        expect_val("kbd_ready_low", c_SEL_READY, 16'h0000);
        drain();
        kbd_code  = 16'h0042;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        expect_val("kbd_held_ignore", c_SEL_INM, 16'h0041);
        drain();
        kbd_release = 1'b1;
        tick();
        kbd_release = 1'b0;
        expect_val("kbd_release", c_SEL_INM, 16'h0000);
        expect_val("kbd_ready_high", c_SEL_READY, 16'h0001);
        drain();
        // valid and release together while idle: valid wins
        kbd_code    = 16'h0063;
        kbd_valid   = 1'b1;
        kbd_release = 1'b1;
        tick();
        kbd_valid   = 1'b0;
        kbd_release = 1'b0;
        addressM    = 15'h6000;
        expect_val("kbd_valid_wins", c_SEL_INM, 16'h0063);
        drain();
        kbd_release = 1'b1;
        tick();
        kbd_release = 1'b0;

        // Screen preload, KBD read-only, unmapped write ignored
        cpu_write(15'h5FFF, 16'hAAAA);
        cpu_write(15'h4000, 16'h5555);
        cpu_write(15'h4005, 16'h1111);
        cpu_write(15'h6000, 16'hFFFF);
        addressM = 15'h6000;
        expect_val("kbd_readonly", c_SEL_INM, 16'h0000);
        drain();
        cpu_write(15'h7FFF, 16'hBEEF);
        addressM = 15'h7FFF;
        expect_val("oor_wr_rd", c_SEL_INM, 16'h0000);
        drain();
        addressM = 15'h5FFF;
        expect_val("oor_wr_no_alias", c_SEL_INM, 16'hAAAA);
        drain();

        // Scanner wrap
        scan_en      = 1'b1;
        frame_pulses = 0;
        for (int i = 0; i < 9000 && scan_addr != 13'd8191; i++) begin
            tick();
            if (frame_start) frame_pulses++;
        end
        expect_val("scan_reach_last", c_SEL_SADDR, 16'd8191);
        drain();
        check("no_early_frame", frame_pulses[15:0], 16'd0);
        tick();
        expect_val("wrap_addr", c_SEL_SADDR, 16'd0);
        expect_val("wrap_frame", c_SEL_FRAME, 16'h0001);
        expect_val("wrap_data_last", c_SEL_SDATA, 16'hAAAA);
        drain();
        tick();
        expect_val("post_wrap_addr", c_SEL_SADDR, 16'd1);
        expect_val("frame_one_cycle", c_SEL_FRAME, 16'h0000);
        expect_val("wrap_data_first", c_SEL_SDATA, 16'h5555);
        drain();

        // Write/scan collision on screen word 5
        for (int i = 0; i < 16 && scan_addr != 13'd5; i++) tick();
        expect_val("coll_at5", c_SEL_SADDR, 16'd5);
        drain();
        cpu_write(15'h4005, 16'h0F0F);
        expect_val("coll_old_data", c_SEL_SDATA, 16'h1111);
        drain();
        addressM = 15'h4005;
        expect_val("coll_cpu_rd", c_SEL_INM, 16'h0F0F);
        drain();
        tick();
        for (int i = 0; i < 9000 && scan_addr != 13'd6; i++) tick();
        expect_val("coll_next_pass", c_SEL_SDATA, 16'h0F0F);
        drain();

        // Asynchronous reset mid-frame
        for (int i = 0; i < 100; i++) tick();
        kbd_code  = 16'h0077;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
        addressM  = 15'h6000;
        expect_val("kbd_before_rst", c_SEL_INM, 16'h0077);
        drain();
        rst = 1'b0;
        expect_val("arst_scan_addr", c_SEL_SADDR, 16'd0);
        expect_val("arst_kbd", c_SEL_INM, 16'h0000);
        expect_val("arst_ready", c_SEL_READY, 16'h0001);
        expect_val("arst_scan_data", c_SEL_SDATA, 16'h0000);
`ifdef HACK_MEM_OOR_TRAP_EN
        expect_val("arst_oor", c_SEL_OOR, 16'h0000);
`endif
        drain();
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_val("restart_addr", c_SEL_SADDR, 16'd1);
        expect_val("restart_no_frame", c_SEL_FRAME, 16'h0000);
        drain();

`ifdef HACK_MEM_OOR_TRAP_EN
        // Sticky out-of-range trap
        addressM = 15'h0000;
        tick();
        expect_val("oor_clear", c_SEL_OOR, 16'h0000);
        drain();
        addressM = 15'h7000;
        expect_val("oor_rd_zero", c_SEL_INM, 16'h0000);
        drain();
        tick();
        addressM = 15'h0000;
        expect_val("oor_set", c_SEL_OOR, 16'h0001);
        drain();
        for (int i = 0; i < 3; i++) tick();
        expect_val("oor_sticky", c_SEL_OOR, 16'h0001);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
